// File: rtl/chacha_move_ctrl.sv
// chacha_move_ctrl: turn and move sequencer that sits upstream of the
// per-player position counters.
//
// When a card is flipped, the controller looks up the picture on the tile
// ahead of the current player. If the tile is occupied by the opponent, it
// looks at the tile after that instead. On a match it drives step_b together
// with the current player's enable, so that player's counter advances one or
// two tiles. On a miss it hands the turn to the other player. It also counts
// laps and declares a winner.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   card_valid      one-cycle pulse: a card has been flipped (sampled in IDLE only)
//   card_id         picture on the flipped card
//   p1_pos, p2_pos  player positions from the counters (taken mod BOARD_LEN)
//   tile_addr       board-picture ROM address (registered)
//   tile_pic        ROM data, combinational from tile_addr
//   step_b          step strobe to the counters' B input
//   p_da1, p_da2    player move enables (never high together)
//   cur_player      0 = player 1, 1 = player 2
//   busy            high in every state except IDLE and DONE
//   match, miss     one-cycle result pulses
//   winner          00 none, 01 player 1, 10 player 2
module chacha_move_ctrl #(
  parameter int unsigned BOARD_LEN = 24,
  parameter int unsigned PIC_W     = 4,
  parameter int unsigned WIN_LAPS  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             card_valid,
  input  logic [PIC_W-1:0] card_id,
  input  logic [4:0]       p1_pos,
  input  logic [4:0]       p2_pos,
  output logic [4:0]       tile_addr,
  input  logic [PIC_W-1:0] tile_pic,
  output logic             step_b,
  output logic             p_da1,
  output logic             p_da2,
  output logic             cur_player,
  output logic             busy,
  output logic             match,
  output logic             miss,
  output logic [1:0]       winner
);

  localparam int unsigned POS_W = 5;
  localparam int unsigned LAP_W = (WIN_LAPS < 2) ? 1 : $clog2(WIN_LAPS + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    CMP    = 3'd2,
    SETUP  = 3'd3,
    STEP   = 3'd4,
    HOLD   = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t           state;
  logic [PIC_W-1:0] card_q;
  logic             skip_q;
  logic             hit_q;
  logic [1:0]       steps_left;
  logic [LAP_W-1:0] lap1;
  logic [LAP_W-1:0] lap2;

  // Reduce a position into 0..BOARD_LEN-1.
  function automatic logic [POS_W-1:0] wrap(input logic [POS_W-1:0] x);
    logic [5:0] w;
    w = 6'(x) % 6'(BOARD_LEN);
    return POS_W'(w);
  endfunction

  // Next tile on the circular board.
  function automatic logic [POS_W-1:0] nxt(input logic [POS_W-1:0] x);
    logic [5:0] t;
    t = 6'(wrap(x)) + 6'd1;
    if (t >= 6'(BOARD_LEN)) t = t - 6'(BOARD_LEN);
    return POS_W'(t);
  endfunction

  logic [POS_W-1:0] own_raw;
  logic [POS_W-1:0] other_raw;
  logic [POS_W-1:0] own_nxt;
  logic [POS_W-1:0] target_c;
  logic             skip_c;
  logic             hit_c;
  logic             at_last_c;
  logic [LAP_W-1:0] cur_lap_c;

  // Target tile: jump over the opponent when it sits directly ahead.
  always_comb begin
    own_raw   = cur_player ? p2_pos : p1_pos;
    other_raw = cur_player ? p1_pos : p2_pos;
    own_nxt   = nxt(own_raw);
    skip_c    = (own_nxt == wrap(other_raw));
    target_c  = skip_c ? nxt(own_nxt) : own_nxt;
  end

  assign hit_c     = (tile_pic == card_q);
  assign at_last_c = (wrap(own_raw) == POS_W'(BOARD_LEN - 1));
  assign cur_lap_c = cur_player ? lap2 : lap1;

  // Sequencer with registered outputs. The tile address is registered on
  // entry to LOOKUP, so the ROM data is already valid during LOOKUP. The
  // compare result is registered on entry to CMP, so miss is visible in CMP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      card_q     <= '0;
      skip_q     <= 1'b0;
      hit_q      <= 1'b0;
      steps_left <= 2'd0;
      lap1       <= '0;
      lap2       <= '0;
      tile_addr  <= '0;
      step_b     <= 1'b0;
      p_da1      <= 1'b0;
      p_da2      <= 1'b0;
      cur_player <= 1'b0;
      busy       <= 1'b0;
      match      <= 1'b0;
      miss       <= 1'b0;
      winner     <= 2'b00;
    end else begin
      match  <= 1'b0;
      miss   <= 1'b0;
      step_b <= 1'b0;
      case (state)
        IDLE: begin
          if (card_valid) begin
            card_q    <= card_id;
            tile_addr <= target_c;
            skip_q    <= skip_c;
            busy      <= 1'b1;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          hit_q      <= hit_c;
          miss       <= ~hit_c;
          steps_left <= skip_q ? 2'd2 : 2'd1;
          state      <= CMP;
        end
        CMP: begin
          if (hit_q) begin
            p_da1 <= ~cur_player;
            p_da2 <= cur_player;
            state <= SETUP;
          end else begin
            cur_player <= ~cur_player;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        SETUP: begin
          step_b <= 1'b1;
          state  <= STEP;
        end
        STEP: begin
          // The counter takes this step at the edge leaving STEP.
          if (at_last_c && (cur_lap_c < LAP_W'(WIN_LAPS))) begin
            if (cur_player) lap2 <= lap2 + LAP_W'(1);
            else            lap1 <= lap1 + LAP_W'(1);
          end
          state <= HOLD;
        end
        HOLD: begin
          steps_left <= steps_left - 2'd1;
          if (steps_left > 2'd1) begin
            state <= SETUP;
          end else begin
            p_da1 <= 1'b0;
            p_da2 <= 1'b0;
            busy  <= 1'b0;
            if (cur_lap_c == LAP_W'(WIN_LAPS)) begin
              winner <= cur_player ? 2'b10 : 2'b01;
              state  <= DONE;
            end else begin
              match <= 1'b1;
              state <= IDLE;
            end
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_move_ctrl.sv
// Directed bench for chacha_move_ctrl with a ROM model and player counters.
module tb_chacha_move_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       card_valid;
  logic [3:0] card_id;
  logic [4:0] p1_pos;
  logic [4:0] p2_pos;
  logic [4:0] tile_addr;
  logic [3:0] tile_pic;
  logic       step_b;
  logic       p_da1;
  logic       p_da2;
  logic       cur_player;
  logic       busy;
  logic       match;
  logic       miss;
  logic [1:0] winner;

  logic [3:0] rom [0:31];
  assign tile_pic = rom[tile_addr];

  int n_checks = 0;
  int n_fail   = 0;

  int n_step, first_step, last_step, en1_cnt, en2_cnt;
  int match_at, miss_at, win_at, busy_cnt, bad_en, addr_lk;

  chacha_move_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .card_valid (card_valid),
    .card_id    (card_id),
    .p1_pos     (p1_pos),
    .p2_pos     (p2_pos),
    .tile_addr  (tile_addr),
    .tile_pic   (tile_pic),
    .step_b     (step_b),
    .p_da1      (p_da1),
    .p_da2      (p_da2),
    .cur_player (cur_player),
    .busy       (busy),
    .match      (match),
    .miss       (miss),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock; the counter model advances on the edge where step_b and an enable were high.
  task automatic cyc();
    logic s1, s2;
    @(negedge clk);
    s1 = step_b & p_da1;
    s2 = step_b & p_da2;
    @(posedge clk);
    #1;
    if (s1) p1_pos = (p1_pos == 5'd23) ? 5'd0 : p1_pos + 5'd1;
    if (s2) p2_pos = (p2_pos == 5'd23) ? 5'd0 : p2_pos + 5'd1;
  endtask

  // Flip one card (cycle 0) and trace ncyc following cycles.
  task automatic run_move(input logic [3:0] card, input int ncyc);
    logic prev_s, prev_e, e;
    n_step = 0; first_step = -1; last_step = -1; en1_cnt = 0; en2_cnt = 0;
    match_at = -1; miss_at = -1; win_at = -1; busy_cnt = 0; bad_en = 0; addr_lk = -1;
    prev_s = 1'b0; prev_e = 1'b0;
    card_valid = 1'b1;
    card_id    = card;
    for (int k = 1; k <= ncyc; k++) begin
      cyc();
      card_valid = 1'b0;
      e = p_da1 | p_da2;
      if (k == 1) addr_lk = int'(tile_addr);
      if (step_b) begin
        n_step++;
        if (first_step < 0) first_step = k;
        last_step = k;
      end
      if (p_da1) en1_cnt++;
      if (p_da2) en2_cnt++;
      if (busy) busy_cnt++;
      if (p_da1 && p_da2) bad_en++;
      if (step_b && !prev_e) bad_en++;
      if (prev_s && !e) bad_en++;
      if (step_b && !e) bad_en++;
      if (match && match_at < 0) match_at = k;
      if (miss && miss_at < 0) miss_at = k;
      if (winner != 2'b00 && win_at < 0) win_at = k;
      prev_s = step_b;
      prev_e = e;
    end
  endtask

  // Assert reset between edges and check that outputs clear without a clock.
  task automatic async_reset(input string tag);
    #1 rst_n = 1'b0;
    #1;
    check({tag, "_step_b"}, int'(step_b), 0);
    check({tag, "_p_da1"},  int'(p_da1),  0);
    check({tag, "_p_da2"},  int'(p_da2),  0);
    check({tag, "_winner"}, int'(winner), 0);
    check({tag, "_busy"},   int'(busy),   0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 4'hF;
    rst_n = 1'b0; card_valid = 1'b0; card_id = 4'd0;
    p1_pos = 5'd3; p2_pos = 5'd10;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tile_addr", int'(tile_addr), 0);
    check("rst_cur_player", int'(cur_player), 0);
    check("rst_strobes", int'({step_b, p_da1, p_da2, match, miss, busy}), 0);
    check("rst_winner", int'(winner), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Simple match: 3 -> 4
    rom[4] = 4'd7;
    run_move(4'd7, 8);
    check("m1_addr", addr_lk, 4);
    check("m1_nstep", n_step, 1);
    check("m1_first_step", first_step, 4);
    check("m1_en1_cycles", en1_cnt, 3);
    check("m1_en2_cycles", en2_cnt, 0);
    check("m1_match_at", match_at, 6);
    check("m1_miss_at", miss_at, -1);
    check("m1_enable_rules", bad_en, 0);
    check("m1_cur_player", int'(cur_player), 0);
    check("m1_p1_pos", int'(p1_pos), 4);

    // Miss by player 1
    p1_pos = 5'd3;
    run_move(4'd2, 5);
    check("miss_nstep", n_step, 0);
    check("miss_enables", en1_cnt + en2_cnt, 0);
    check("miss_at", miss_at, 2);
    check("miss_match_at", match_at, -1);
    check("miss_cur_player", int'(cur_player), 1);

    // Miss by player 2 returns the turn
    p2_pos = 5'd10;
    run_move(4'd2, 5);
    check("miss2_addr", addr_lk, 11);
    check("miss2_at", miss_at, 2);
    check("miss2_cur_player", int'(cur_player), 0);

    // Skip over opponent: 5 -> 7 with 6 occupied
    p1_pos = 5'd5; p2_pos = 5'd6;
    rom[7] = 4'd9;
    run_move(4'd9, 11);
    check("skip_addr", addr_lk, 7);
    check("skip_nstep", n_step, 2);
    check("skip_first_step", first_step, 4);
    check("skip_last_step", last_step, 7);
    check("skip_en1_cycles", en1_cnt, 6);
    check("skip_enable_rules", bad_en, 0);
    check("skip_match_at", match_at, 9);
    check("skip_p1_pos", int'(p1_pos), 7);

    // Hand the turn to player 2
    p1_pos = 5'd3; p2_pos = 5'd10;
    run_move(4'd2, 5);
    check("pass_cur_player", int'(cur_player), 1);

    // Wrap with skip for player 2: 22 -> 0 over 23, lap on second step wins
    p2_pos = 5'd22; p1_pos = 5'd23;
    rom[0] = 4'd3;
    run_move(4'd3, 11);
    check("wskip_addr", addr_lk, 0);
    check("wskip_nstep", n_step, 2);
    check("wskip_en2_cycles", en2_cnt, 6);
    check("wskip_en1_cycles", en1_cnt, 0);
    check("wskip_enable_rules", bad_en, 0);
    check("wskip_win_at", win_at, 9);
    check("wskip_winner", int'(winner), 2);
    check("wskip_match_at", match_at, -1);
    check("wskip_p2_pos", int'(p2_pos), 0);
    check("wskip_busy", int'(busy), 0);

    async_reset("rst_after_p2win");
    check("rst2_cur_player", int'(cur_player), 0);

    // Wrap and win for player 1: 23 -> 0
    p1_pos = 5'd23; p2_pos = 5'd5;
    rom[0] = 4'd1;
    run_move(4'd1, 8);
    check("win_addr", addr_lk, 0);
    check("win_nstep", n_step, 1);
    check("win_at", win_at, 6);
    check("win_winner", int'(winner), 1);
    check("win_p1_pos", int'(p1_pos), 0);

    // Cards are ignored in DONE
    run_move(4'd1, 4);
    check("done_busy_cycles", busy_cnt, 0);
    check("done_strobes", n_step + en1_cnt + en2_cnt, 0);
    check("done_winner", int'(winner), 1);

    async_reset("rst_in_done");

    // Card during STEP is ignored; reset asserted in HOLD
    p1_pos = 5'd3; p2_pos = 5'd10;
    rom[4] = 4'd7;
    card_valid = 1'b1; card_id = 4'd7;
    cyc();
    card_valid = 1'b0;
    cyc(); cyc(); cyc();
    check("bsy_step_b", int'(step_b), 1);
    card_valid = 1'b1;
    cyc();
    card_valid = 1'b0;
    check("bsy_hold_p_da1", int'(p_da1), 1);
    check("bsy_hold_step_b", int'(step_b), 0);
    check("bsy_hold_busy", int'(busy), 1);
    async_reset("rst_in_hold");
    check("rst_hold_tile_addr", int'(tile_addr), 0);

    // Out-of-range position: 27 is taken as 3
    p1_pos = 5'd27; p2_pos = 5'd10;
    run_move(4'd7, 8);
    check("oor_addr", addr_lk, 4);
    check("oor_nstep", n_step, 1);
    check("oor_match_at", match_at, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chacha_move_ctrl.md
Name: chacha_move_ctrl

Overview:
- Turn and move sequencer that sits directly upstream of the per-player position counters (cnt_player1 / cnt_player2).
- Takes a flipped-card event, looks up the picture on the tile ahead of the current player and compares it with the card.
- On a match it drives the step strobe plus the matching player-enable (p_da1/p_da2) so that exactly one counter advances; on a miss it passes the turn.
- Also tracks laps and declares a winner.

Parameters:
- BOARD_LEN, 24, number of tiles; positions are 0..BOARD_LEN-1.
- PIC_W, 4, width of card/tile picture code.
- WIN_LAPS, 1, completed laps needed to win.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- card_valid  in  1  one-cycle pulse: a card has been flipped.
- card_id  in  PIC_W  picture on flipped card; sampled when card_valid=1.
- p1_pos  in  5  player-1 position, from the player-1 counter.
- p2_pos  in  5  player-2 position, from the player-2 counter.
- tile_addr  out  5  address to the external board-picture ROM.
- tile_pic  in  PIC_W  ROM data; combinational from tile_addr and valid in the same cycle.
- step_b  out  1  step strobe to the counters' B input.
- p_da1  out  1  player-1 move enable.
- p_da2  out  1  player-2 move enable.
- cur_player  out  1  0 = player 1, 1 = player 2.
- busy  out  1  high in every state except IDLE and DONE.
- match  out  1  one-cycle pulse: the card matched.
- miss  out  1  one-cycle pulse: the card missed and the turn passed.
- winner  out  2  00 = none, 01 = player 1, 10 = player 2.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, tile_addr=0, step_b=0, p_da1=0, p_da2=0, cur_player=0, match=0, miss=0, winner=00, both lap counters=0, card register=0.
- Definitions:
  - own = current player's position; other = the other player's position.
  - nxt(x) = x+1, with BOARD_LEN-1 wrapping to 0. Computed in 6 bits, then reduced mod BOARD_LEN.
- IDLE: if card_valid=1, latch card_id, go to LOOKUP. card_valid is ignored in all other states, with no queueing.
- LOOKUP (1 cycle): tile_addr = nxt(own). If nxt(own)==other, set skip=1 and tile_addr = nxt(nxt(own)). The occupied tile is jumped over.
- CMP (1 cycle): tile_addr held.
  - tile_pic==card: set steps_left = 1+skip, go to SETUP.
  - Otherwise: miss=1 for this cycle, toggle cur_player, go to IDLE.
- SETUP (1 cycle): enable of the current player = 1, step_b = 0.
- STEP (1 cycle): step_b = 1, enable held. The counter advances on this rising edge.
  - If own==BOARD_LEN-1 at entry, increment the current player's lap counter (saturating at WIN_LAPS).
- HOLD (1 cycle): step_b = 0, enable held; decrement steps_left.
  - If it is nonzero, go back to SETUP. The enable stays high through the gap; the next step_b rises 2 cycles after the previous fall.
- After the final HOLD: enables drop to 0.
  - If the current lap counter == WIN_LAPS: winner = current player, go to DONE.
  - Otherwise: match=1 for one cycle, go to IDLE. cur_player is unchanged, so the same player flips again.
- Latency: card_valid to first step_b rise = 4 cycles (IDLE→LOOKUP→CMP→SETUP→STEP). A miss is reported 2 cycles after card_valid.
- Enable rules:
  - p_da1 and p_da2 are never high together.
  - Each enable is high for at least 1 full cycle before and after every step_b high cycle.
  - step_b is high for exactly 1 cycle per step.
- DONE: all strobes 0; winner, cur_player and busy=0 are held. Only rst_n leaves DONE.
- Reset mid-move: every output returns to its reset value immediately, including step_b and the enables. Positions are owned by the counters and are not restored here.
- Out-of-range inputs: a p*_pos value >= BOARD_LEN is taken mod BOARD_LEN. The lap is still counted only on the BOARD_LEN-1 → 0 step.

Test Plan:
- Simple match: reset; p1_pos=3, p2_pos=10, ROM[4]=7, card_valid with card_id=7. Required: tile_addr=4 in LOOKUP; p_da1=1 for 3 cycles; exactly one step_b pulse at cycle 4; match pulse; cur_player stays 0; p_da2 never asserts.
- Miss: p1_pos=3, ROM[4]=7, card_id=2. Required: no step_b, no enables; miss pulse at cycle 2; cur_player→1.
- Skip over opponent: p1_pos=5, p2_pos=6, ROM[7]=9, card_id=9. Required: tile_addr=7; two step_b pulses with p_da1 continuously high; match pulse.
- Wrap and win: WIN_LAPS=1, p1_pos=23, p2_pos=5, ROM[0]=1, card_id=1. Required: tile_addr=0; one step; winner=01; DONE; a later card_valid is ignored (busy=0, no strobes).
- Wrap with skip: p2 current, p2_pos=22, p1_pos=23, ROM[0]=3, card_id=3. Required: tile_addr=0; two steps via p_da2; lap counted on the second step.
- Busy/reset: card_valid pulsed again during STEP is ignored; rst_n=0 asserted in HOLD. Required: step_b, p_da1, p_da2 and winner drop to 0 asynchronously, with no clock edge needed.
